microwave_timer: RTL and testbench

Front-panel time-entry and countdown controller for the microwave. It takes keypad digits, start/stop-clear buttons, the door switch and a 1 Hz tick enable, and produces the three BCD digits (`sec_ones`, `sec_tens`, `mins`) consumed by `seg7_driver`. It also drives magnetron enable and a done flag. It is the producer of the BCD display interface that `seg7_driver` decodes.

---
 rtl/microwave_timer_if.sv | 25 ++
 rtl/microwave_timer.sv | 175 +++++++++++++++++
 tb/tb_microwave_timer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/microwave_timer_if.sv
// microwave_timer_if: front-panel controls into the timer and BCD display/status
// out of it. The panel side is the master, the timer is the slave.
interface microwave_timer_if;
    logic       tick_1hz;
    logic [3:0] key_val;
    logic       key_valid;
    logic       start;
    logic       stop_clear;
    logic       door_closed;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] mins;
    logic       mag_on;
    logic       done;

    modport master (
        output tick_1hz, key_val, key_valid, start, stop_clear, door_closed,
        input  sec_ones, sec_tens, mins, mag_on, done
    );

    modport slave (
        input  tick_1hz, key_val, key_valid, start, stop_clear, door_closed,
        output sec_ones, sec_tens, mins, mag_on, done
    );
endinterface

// File: rtl/microwave_timer.sv
// microwave_timer: keypad time entry and 1 Hz BCD countdown for the microwave
// front panel, producing the m:ss digits for seg7_driver plus magnetron enable
// and done flag. Define MW_ADD30_EN to enable the quick-start / add-30-seconds
// behaviour of the start button.
//
// state  | meaning
// IDLE   | time entry by keypad, magnetron off
// RUN    | counting down on tick_1hz, magnetron on
// PAUSED | countdown held, digits kept, waiting for start or clear
// DONE   | reached 0:00, done flag up until any button is pressed
module microwave_timer #(
    parameter int unsigned MAX_MINS = 9
) (
    input  logic             clk,
    input  logic             reset,
    microwave_timer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] MAX_MINS_D = 4'(MAX_MINS);

    state_t     state;
    logic [3:0] sec_ones_q, sec_tens_q, mins_q;
    logic       mag_on_q, done_q;

    logic [3:0] dec_ones, dec_tens, dec_mins;
    logic       dec_zero;
    logic       time_zero;
    logic       key_ok;

    assign time_zero = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) && (mins_q == 4'd0);

    // A shifted-in key must keep every digit legal after the shift.
    assign key_ok = (bus.key_val <= 4'd9) && (sec_ones_q <= 4'd5) && (sec_tens_q <= MAX_MINS_D);

    // One-second BCD borrow chain; never evaluated from 0:00 because RUN leaves at 0:00.
    always_comb begin
        dec_ones = sec_ones_q;
        dec_tens = sec_tens_q;
        dec_mins = mins_q;
        if (sec_ones_q != 4'd0) begin
            dec_ones = sec_ones_q - 4'd1;
        end else begin
            dec_ones = 4'd9;
            if (sec_tens_q != 4'd0) begin
                dec_tens = sec_tens_q - 4'd1;
            end else begin
                dec_tens = 4'd5;
                dec_mins = mins_q - 4'd1;
            end
        end
        dec_zero = (dec_ones == 4'd0) && (dec_tens == 4'd0) && (dec_mins == 4'd0);
    end

`ifdef MW_ADD30_EN
    logic [3:0] add_ones, add_tens, add_mins;

    // +30 s: tens+3 carries into minutes from 3 upward; saturate at MAX_MINS:59.
    always_comb begin
        add_ones = sec_ones_q;
        add_tens = sec_tens_q + 4'd3;
        add_mins = mins_q;
        if (sec_tens_q >= 4'd3) begin
            if (mins_q >= MAX_MINS_D) begin
                add_mins = MAX_MINS_D;
                add_tens = 4'd5;
                add_ones = 4'd9;
            end else begin
                add_mins = mins_q + 4'd1;
                add_tens = sec_tens_q - 4'd3;
            end
        end
    end
`endif

    // Controller FSM; one event per cycle in priority order, outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            mins_q     <= 4'd0;
            mag_on_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.stop_clear) begin
                        sec_ones_q <= 4'd0;
                        sec_tens_q <= 4'd0;
                        mins_q     <= 4'd0;
                    end else if (bus.start) begin
                        // A start press always consumes the cycle; door open just blocks it.
                        if (bus.door_closed) begin
                            if (!time_zero) begin
                                state    <= S_RUN;
                                mag_on_q <= 1'b1;
                            end
`ifdef MW_ADD30_EN
                            else begin
                                sec_tens_q <= 4'd3;
                                state      <= S_RUN;
                                mag_on_q   <= 1'b1;
                            end
`endif
                        end
                    end else if (bus.key_valid && key_ok) begin
                        mins_q     <= sec_tens_q;
                        sec_tens_q <= sec_ones_q;
                        sec_ones_q <= bus.key_val;
                    end
                end
                S_RUN: begin
                    if (bus.stop_clear || !bus.door_closed) begin
                        state    <= S_PAUSED;
                        mag_on_q <= 1'b0;
                    end
`ifdef MW_ADD30_EN
                    else if (bus.start) begin
                        sec_ones_q <= add_ones;
                        sec_tens_q <= add_tens;
                        mins_q     <= add_mins;
                    end
`endif
                    else if (bus.tick_1hz) begin
                        sec_ones_q <= dec_ones;
                        sec_tens_q <= dec_tens;
                        mins_q     <= dec_mins;
                        if (dec_zero) begin
                            state    <= S_DONE;
                            mag_on_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                S_PAUSED: begin
                    if (bus.stop_clear) begin
                        state      <= S_IDLE;
                        sec_ones_q <= 4'd0;
                        sec_tens_q <= 4'd0;
                        mins_q     <= 4'd0;
                    end else if (bus.start && bus.door_closed) begin
                        state    <= S_RUN;
                        mag_on_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.start || bus.stop_clear || bus.key_valid) begin
                        state      <= S_IDLE;
                        done_q     <= 1'b0;
                        sec_ones_q <= 4'd0;
                        sec_tens_q <= 4'd0;
                        mins_q     <= 4'd0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    mag_on_q <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sec_ones = sec_ones_q;
    assign bus.sec_tens = sec_tens_q;
    assign bus.mins     = mins_q;
    assign bus.mag_on   = mag_on_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_microwave_timer.sv
// tb_microwave_timer: scenario bench for microwave_timer. Expected display and
// status are queued as each cycle's stimulus is driven and checked one clock
// later. Add-30 expectations follow MW_ADD30_EN when it is defined.
module tb_microwave_timer;
    logic clk;
    logic reset;

    microwave_timer_if bus ();

    microwave_timer #(.MAX_MINS(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] kv;
        logic       kvld, st, sc, dc, tk;
        logic [3:0] e_mins, e_tens, e_ones;
        logic       e_mag, e_done;
    } row_t;

    row_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // t is the expected display written as m*100 + ss.
    function automatic row_t r(input string n, input logic rst, input logic [3:0] kv,
                               input logic kvld, input logic st, input logic sc,
                               input logic dc, input logic tk, input int t,
                               input logic mag, input logic dn);
        row_t x;
        x.name = n; x.rst = rst; x.kv = kv; x.kvld = kvld; x.st = st; x.sc = sc;
        x.dc = dc; x.tk = tk;
        x.e_mins = 4'(t / 100);
        x.e_tens = 4'((t / 10) % 10);
        x.e_ones = 4'(t % 10);
        x.e_mag = mag; x.e_done = dn;
        return x;
    endfunction

    function automatic int mmss(input int s);
        return (s / 60) * 100 + (s % 60);
    endfunction

    task automatic apply(input row_t x);
        reset           = x.rst;
        bus.key_val     = x.kv;
        bus.key_valid   = x.kvld;
        bus.start       = x.st;
        bus.stop_clear  = x.sc;
        bus.door_closed = x.dc;
        bus.tick_1hz    = x.tk;
        sb.push_back(x);
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.key_valid  = 1'b0;
        bus.start      = 1'b0;
        bus.stop_clear = 1'b0;
        bus.tick_1hz   = 1'b0;
    endtask

    task automatic test_reset();
        row_t e;
        bus.key_val = 4'd3; bus.key_valid = 1'b1; bus.start = 1'b1;
        apply(r("reset", 1, 4'd3, 1, 1, 0, 1, 1, 0, 0, 0));
        e = sb.pop_front();
        vectors++;
        if ({bus.mins, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.done} !==
            {e.e_mins, e.e_tens, e.e_ones, e.e_mag, e.e_done}) begin
            miscompares++;
            $display("FAIL %s: got %0d:%0d%0d mag_on=%b done=%b, want %0d:%0d%0d mag_on=%b done=%b",
                     e.name, bus.mins, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.done,
                     e.e_mins, e.e_tens, e.e_ones, e.e_mag, e.e_done);
        end
    endtask

    task automatic test_entry_run();
        row_t rows[$];
        row_t e;
        int   s;
        rows.push_back(r("rst",     1, 0, 0, 0, 0, 1, 0,   0, 0, 0));
        rows.push_back(r("key1",    0, 1, 1, 0, 0, 1, 0,   1, 0, 0));
        rows.push_back(r("key3",    0, 3, 1, 0, 0, 1, 0,  13, 0, 0));
        rows.push_back(r("key0",    0, 0, 1, 0, 0, 1, 0, 130, 0, 0));
        rows.push_back(r("start",   0, 0, 0, 1, 0, 1, 0, 130, 1, 0));
        rows.push_back(r("tick1",   0, 0, 0, 0, 0, 1, 1, 129, 1, 0));
        s = 89;
        for (int i = 0; i < 29; i++) begin
            s--;
            rows.push_back(r("tick_n", 0, 0, 0, 0, 0, 1, 1, mmss(s), 1, 0));
        end
        rows.push_back(r("tick31",  0, 0, 0, 0, 0, 1, 1,  59, 1, 0));
        rows.push_back(r("run_key", 0, 5, 1, 0, 0, 1, 0,  59, 1, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            vectors++;
            if ({bus.mins, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.done} !==
                {e.e_mins, e.e_tens, e.e_ones, e.e_mag, e.e_done}) begin
                miscompares++;
                $display("FAIL %s: got %0d:%0d%0d mag_on=%b done=%b, want %0d:%0d%0d mag_on=%b done=%b",
                         e.name, bus.mins, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.done,
                         e.e_mins, e.e_tens, e.e_ones, e.e_mag, e.e_done);
            end
        end
    endtask

    task automatic test_done();
        row_t rows[$];
        row_t e;
        rows.push_back(r("rst",       1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        rows.push_back(r("key2",      0, 2, 1, 0, 0, 1, 0, 2, 0, 0));
        rows.push_back(r("start",     0, 0, 0, 1, 0, 1, 0, 2, 1, 0));
        rows.push_back(r("tick_a",    0, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        rows.push_back(r("tick_zero", 0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        rows.push_back(r("done_hold", 0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        rows.push_back(r("done_key",  0, 5, 1, 0, 0, 1, 0, 0, 0, 0));
        rows.push_back(r("idle_key",  0, 5, 1, 0, 0, 1, 0, 5, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            vectors++;
            if ({bus.mins, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.done} !==
                {e.e_mins, e.e_tens, e.e_ones, e.e_mag, e.e_done}) begin
                miscompares++;
                $display("FAIL %s: got %0d:%0d%0d mag_on=%b done=%b, want %0d:%0d%0d mag_on=%b done=%b",
                         e.name, bus.mins, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.done,
                         e.e_mins, e.e_tens, e.e_ones, e.e_mag, e.e_done);
            end
        end
    endtask

    task automatic test_pause();
        row_t rows[$];
        row_t e;
        rows.push_back(r("rst",         1, 0, 0, 0, 0, 1, 0,  0, 0, 0));
        rows.push_back(r("key4",        0, 4, 1, 0, 0, 1, 0,  4, 0, 0));
        rows.push_back(r("key5",        0, 5, 1, 0, 0, 1, 0, 45, 0, 0));
        rows.push_back(r("start_open",  0, 0, 0, 1, 0, 0, 0, 45, 0, 0));
        rows.push_back(r("start",       0, 0, 0, 1, 0, 1, 0, 45, 1, 0));
        rows.push_back(r("door_open",   0, 0, 0, 0, 0, 0, 0, 45, 0, 0));
        rows.push_back(r("tick_open",   0, 0, 0, 0, 0, 0, 1, 45, 0, 0));
        rows.push_back(r("tick_paused", 0, 0, 0, 0, 0, 1, 1, 45, 0, 0));
        rows.push_back(r("key_paused",  0, 7, 1, 0, 0, 1, 0, 45, 0, 0));
        rows.push_back(r("resume",      0, 0, 0, 1, 0, 1, 0, 45, 1, 0));
        rows.push_back(r("tick",        0, 0, 0, 0, 0, 1, 1, 44, 1, 0));
        rows.push_back(r("stop1",       0, 0, 0, 0, 1, 1, 0, 44, 0, 0));
        rows.push_back(r("stop2",       0, 0, 0, 0, 1, 1, 0,  0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            vectors++;
            if ({bus.mins, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.done} !==
                {e.e_mins, e.e_tens, e.e_ones, e.e_mag, e.e_done}) begin
                miscompares++;
                $display("FAIL %s: got %0d:%0d%0d mag_on=%b done=%b, want %0d:%0d%0d mag_on=%b done=%b",
                         e.name, bus.mins, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.done,
                         e.e_mins, e.e_tens, e.e_ones, e.e_mag, e.e_done);
            end
        end
    endtask

    task automatic test_entry_reject();
        row_t rows[$];
        row_t e;
        rows.push_back(r("rst",      1,  0, 0, 0, 0, 1, 0,   0, 0, 0));
        rows.push_back(r("key9",     0,  9, 1, 0, 0, 1, 0,   9, 0, 0));
        rows.push_back(r("key7_rej", 0,  7, 1, 0, 0, 1, 0,   9, 0, 0));
        rows.push_back(r("key12",    0, 12, 1, 0, 0, 1, 0,   9, 0, 0));
        rows.push_back(r("clear",    0,  0, 0, 0, 1, 1, 0,   0, 0, 0));
        rows.push_back(r("key5",     0,  5, 1, 0, 0, 1, 0,   5, 0, 0));
        rows.push_back(r("key9b",    0,  9, 1, 0, 0, 1, 0,  59, 0, 0));
        rows.push_back(r("key4_rej", 0,  4, 1, 0, 0, 1, 0,  59, 0, 0));
        rows.push_back(r("clear2",   0,  0, 0, 0, 1, 1, 0,   0, 0, 0));
        rows.push_back(r("k5",       0,  5, 1, 0, 0, 1, 0,   5, 0, 0));
        rows.push_back(r("k5b",      0,  5, 1, 0, 0, 1, 0,  55, 0, 0));
        rows.push_back(r("k0",       0,  0, 1, 0, 0, 1, 0, 550, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            vectors++;
            if ({bus.mins, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.done} !==
                {e.e_mins, e.e_tens, e.e_ones, e.e_mag, e.e_done}) begin
                miscompares++;
                $display("FAIL %s: got %0d:%0d%0d mag_on=%b done=%b, want %0d:%0d%0d mag_on=%b done=%b",
                         e.name, bus.mins, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.done,
                         e.e_mins, e.e_tens, e.e_ones, e.e_mag, e.e_done);
            end
        end
    endtask

    task automatic test_reset_midrun();
        row_t rows[$];
        row_t e;
        rows.push_back(r("rst",        1, 0, 0, 0, 0, 1, 0,   0, 0, 0));
        rows.push_back(r("key3",       0, 3, 1, 0, 0, 1, 0,   3, 0, 0));
        rows.push_back(r("key2",       0, 2, 1, 0, 0, 1, 0,  32, 0, 0));
        rows.push_back(r("key1",       0, 1, 1, 0, 0, 1, 0, 321, 0, 0));
        rows.push_back(r("start",      0, 0, 0, 1, 0, 1, 1, 321, 1, 0));
        rows.push_back(r("rst_run",    1, 0, 0, 0, 0, 1, 1,   0, 0, 0));
        rows.push_back(r("key4",       0, 4, 1, 0, 0, 1, 0,   4, 0, 0));
        rows.push_back(r("key0",       0, 0, 1, 0, 0, 1, 0,  40, 0, 0));
        rows.push_back(r("start2",     0, 0, 0, 1, 0, 1, 0,  40, 1, 0));
        rows.push_back(r("pause",      0, 0, 0, 0, 1, 1, 0,  40, 0, 0));
        rows.push_back(r("start_stop", 0, 0, 0, 1, 1, 1, 0,   0, 0, 0));
`ifdef MW_ADD30_EN
        rows.push_back(r("start_zero", 0, 0, 0, 1, 0, 1, 0,  30, 1, 0));
`else
        rows.push_back(r("start_zero", 0, 0, 0, 1, 0, 1, 0,   0, 0, 0));
`endif
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            vectors++;
            if ({bus.mins, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.done} !==
                {e.e_mins, e.e_tens, e.e_ones, e.e_mag, e.e_done}) begin
                miscompares++;
                $display("FAIL %s: got %0d:%0d%0d mag_on=%b done=%b, want %0d:%0d%0d mag_on=%b done=%b",
                         e.name, bus.mins, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.done,
                         e.e_mins, e.e_tens, e.e_ones, e.e_mag, e.e_done);
            end
        end
    endtask

    task automatic test_add30();
        row_t rows[$];
        row_t e;
`ifdef MW_ADD30_EN
        int s;
        rows.push_back(r("rst",        1, 0, 0, 0, 0, 1, 0,   0, 0, 0));
        rows.push_back(r("quick",      0, 0, 0, 1, 0, 1, 1,  30, 1, 0));
        rows.push_back(r("tick",       0, 0, 0, 0, 0, 1, 1,  29, 1, 0));
        rows.push_back(r("rst2",       1, 0, 0, 0, 0, 1, 0,   0, 0, 0));
        rows.push_back(r("key4",       0, 4, 1, 0, 0, 1, 0,   4, 0, 0));
        rows.push_back(r("key5",       0, 5, 1, 0, 0, 1, 0,  45, 0, 0));
        rows.push_back(r("start",      0, 0, 0, 1, 0, 1, 0,  45, 1, 0));
        rows.push_back(r("add_carry",  0, 0, 0, 1, 0, 1, 0, 115, 1, 0));
        rows.push_back(r("rst3",       1, 0, 0, 0, 0, 1, 0,   0, 0, 0));
        rows.push_back(r("k5",         0, 5, 1, 0, 0, 1, 0,   5, 0, 0));
        rows.push_back(r("k5b",        0, 5, 1, 0, 0, 1, 0,  55, 0, 0));
        rows.push_back(r("k0",         0, 0, 1, 0, 0, 1, 0, 550, 0, 0));
        rows.push_back(r("start550",   0, 0, 0, 1, 0, 1, 0, 550, 1, 0));
        s = 5 * 60 + 50;
        for (int i = 0; i < 8; i++) begin
            s += 30;
            rows.push_back(r("add_n", 0, 0, 0, 1, 0, 1, 0, mmss(s), 1, 0));
        end
        rows.push_back(r("add_sat",    0, 0, 0, 1, 0, 1, 0, 959, 1, 0));
        rows.push_back(r("add_tick",   0, 0, 0, 1, 0, 1, 1, 959, 1, 0));
        rows.push_back(r("tick_after", 0, 0, 0, 0, 0, 1, 1, 958, 1, 0));
`else
        rows.push_back(r("rst",        1, 0, 0, 0, 0, 1, 0,  0, 0, 0));
        rows.push_back(r("zero_start", 0, 0, 0, 1, 0, 1, 0,  0, 0, 0));
        rows.push_back(r("key4",       0, 4, 1, 0, 0, 1, 0,  4, 0, 0));
        rows.push_back(r("key5",       0, 5, 1, 0, 0, 1, 0, 45, 0, 0));
        rows.push_back(r("start",      0, 0, 0, 1, 0, 1, 0, 45, 1, 0));
        rows.push_back(r("start_run",  0, 0, 0, 1, 0, 1, 0, 45, 1, 0));
        rows.push_back(r("tick",       0, 0, 0, 0, 0, 1, 1, 44, 1, 0));
`endif
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            vectors++;
            if ({bus.mins, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.done} !==
                {e.e_mins, e.e_tens, e.e_ones, e.e_mag, e.e_done}) begin
                miscompares++;
                $display("FAIL %s: got %0d:%0d%0d mag_on=%b done=%b, want %0d:%0d%0d mag_on=%b done=%b",
                         e.name, bus.mins, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.done,
                         e.e_mins, e.e_tens, e.e_ones, e.e_mag, e.e_done);
            end
        end
    endtask

    initial begin
        clk             = 1'b0;
        reset           = 1'b1;
        bus.tick_1hz    = 1'b0;
        bus.key_val     = 4'd0;
        bus.key_valid   = 1'b0;
        bus.start       = 1'b0;
        bus.stop_clear  = 1'b0;
        bus.door_closed = 1'b1;
        test_reset();
        test_entry_run();
        test_done();
        test_pause();
        test_entry_reject();
        test_reset_midrun();
        test_add30();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
